// File: rtl/draw_sched.sv
// draw_sched: draw command scheduler between the command decoder and the
// line / flip drawing engines. Accepts one draw command at a time (polyline
// segment, triangle outline, frame flip), sequences the engines, splits a
// triangle into three line segments and owns the single frame write port.
//
// Ports:
//   iClk, iRst_              system clock, asynchronous active-low reset
//   iGo, iPolyline/iTriangle/iFlip, iColor, iX0..iY2
//                            command strobe, type flags, color, vertices
//   oDone                    idle and ready for iGo
//   oLineGo, oLineX0..oLineY1, iLineDone, iLineAdr, iLineWrEn
//                            line engine start, segment, done, write request
//   oFlipGo, iFlipDone, iFlipAdr, iFlipWrEn
//                            flip engine start, done, write request
//   oAdr, oD, oWrEn          frame write port
//   oBusyErr, oCmdErr        sticky error flags (cleared only by reset)
module draw_sched #(
  parameter int ADR_W = 16,
  parameter int CRD_W = 8,
  parameter int COL_W = 9
) (
  input  logic             iClk,
  input  logic             iRst_,
  input  logic             iGo,
  input  logic             iPolyline,
  input  logic             iTriangle,
  input  logic             iFlip,
  input  logic [COL_W-1:0] iColor,
  input  logic [CRD_W-1:0] iX0,
  input  logic [CRD_W-1:0] iY0,
  input  logic [CRD_W-1:0] iX1,
  input  logic [CRD_W-1:0] iY1,
  input  logic [CRD_W-1:0] iX2,
  input  logic [CRD_W-1:0] iY2,
  output logic             oDone,
  output logic             oLineGo,
  output logic [CRD_W-1:0] oLineX0,
  output logic [CRD_W-1:0] oLineY0,
  output logic [CRD_W-1:0] oLineX1,
  output logic [CRD_W-1:0] oLineY1,
  input  logic             iLineDone,
  input  logic [ADR_W-1:0] iLineAdr,
  input  logic             iLineWrEn,
  output logic             oFlipGo,
  input  logic             iFlipDone,
  input  logic [ADR_W-1:0] iFlipAdr,
  input  logic             iFlipWrEn,
  output logic [ADR_W-1:0] oAdr,
  output logic [COL_W-1:0] oD,
  output logic             oWrEn,
  output logic             oBusyErr,
  output logic             oCmdErr
);

  typedef enum logic [2:0] {
    S_IDLE, S_LGO, S_LARM, S_LWAIT, S_FGO, S_FARM, S_FWAIT
  } state_t;

  state_t           r_state;
  logic [1:0]       r_e;        // triangle edge index
  logic             r_tri;
  logic [COL_W-1:0] r_col;
  logic [CRD_W-1:0] r_x0, r_y0, r_x1, r_y1, r_x2, r_y2;
  logic [ADR_W-1:0] r_adr;      // last address driven, held while idle
  logic             r_busy_err;
  logic             r_cmd_err;

  logic [1:0]       w_flag_cnt;
  logic             w_flag_ok;
  logic             w_line_ph;
  logic             w_flip_ph;

  assign w_flag_cnt = {1'b0, iPolyline} + {1'b0, iTriangle} + {1'b0, iFlip};
  assign w_flag_ok  = (w_flag_cnt == 2'd1);
  assign w_line_ph  = (r_state == S_LGO) || (r_state == S_LARM) || (r_state == S_LWAIT);
  assign w_flip_ph  = (r_state == S_FGO) || (r_state == S_FARM) || (r_state == S_FWAIT);

  always_ff @(posedge iClk or negedge iRst_) begin
    if (!iRst_) begin
      r_state    <= S_IDLE;
      r_e        <= 2'd0;
      r_tri      <= 1'b0;
      r_col      <= '0;
      r_x0       <= '0;
      r_y0       <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_x2       <= '0;
      r_y2       <= '0;
      r_adr      <= '0;
      r_busy_err <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      // A strobe while a command runs is flagged and otherwise ignored.
      if (iGo && (r_state != S_IDLE))
        r_busy_err <= 1'b1;
      // Track the port address so it holds its last value once idle.
      if (r_state != S_IDLE)
        r_adr <= oAdr;

      case (r_state)
        S_IDLE: begin
          if (iGo) begin
            if (w_flag_ok) begin
              r_col   <= iColor;
              r_x0    <= iX0;
              r_y0    <= iY0;
              r_x1    <= iX1;
              r_y1    <= iY1;
              r_x2    <= iX2;
              r_y2    <= iY2;
              r_tri   <= iTriangle;
              r_e     <= 2'd0;
              r_state <= iFlip ? S_FGO : S_LGO;
            end else begin
              r_cmd_err <= 1'b1;
            end
          end
        end
        S_LGO:  r_state <= S_LARM;
        // Guard cycle: the engine may still show done from before the go.
        S_LARM: r_state <= S_LWAIT;
        S_LWAIT: begin
          if (iLineDone) begin
            if (r_tri && (r_e < 2'd2)) begin
              r_e     <= r_e + 2'd1;
              r_state <= S_LGO;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_FGO:  r_state <= S_FARM;
        S_FARM: r_state <= S_FWAIT;
        S_FWAIT: begin
          if (iFlipDone)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Segment endpoints follow the edge index; stable for a whole segment.
  always_comb begin
    oLineX0 = r_x2;
    oLineY0 = r_y2;
    oLineX1 = r_x0;
    oLineY1 = r_y0;
    case (r_e)
      2'd0: begin
        oLineX0 = r_x0;
        oLineY0 = r_y0;
        oLineX1 = r_x1;
        oLineY1 = r_y1;
      end
      2'd1: begin
        oLineX0 = r_x1;
        oLineY0 = r_y1;
        oLineX1 = r_x2;
        oLineY1 = r_y2;
      end
      default: ;
    endcase
  end

  // Frame write port: owned by whichever engine the current command uses.
  always_comb begin
    oAdr  = r_adr;
    oWrEn = 1'b0;
    if (w_line_ph) begin
      oAdr  = iLineAdr;
      oWrEn = iLineWrEn;
    end else if (w_flip_ph) begin
      oAdr  = iFlipAdr;
      oWrEn = iFlipWrEn;
    end
  end

  assign oD       = r_col;
  assign oDone    = (r_state == S_IDLE);
  assign oLineGo  = (r_state == S_LGO);
  assign oFlipGo  = (r_state == S_FGO);
  assign oBusyErr = r_busy_err;
  assign oCmdErr  = r_cmd_err;

endmodule

// File: tb/tb_draw_sched.sv
module tb_draw_sched;
  localparam int ADR_W = 16;
  localparam int CRD_W = 8;
  localparam int COL_W = 9;

  logic             iClk = 1'b0;
  logic             iRst_ = 1'b0;
  logic             iGo = 1'b0;
  logic             iPolyline = 1'b0, iTriangle = 1'b0, iFlip = 1'b0;
  logic [COL_W-1:0] iColor = '0;
  logic [CRD_W-1:0] iX0 = '0, iY0 = '0, iX1 = '0, iY1 = '0, iX2 = '0, iY2 = '0;
  logic             oDone, oLineGo, oFlipGo, oWrEn, oBusyErr, oCmdErr;
  logic [CRD_W-1:0] oLineX0, oLineY0, oLineX1, oLineY1;
  logic             iLineDone = 1'b1, iFlipDone = 1'b1;
  logic [ADR_W-1:0] iLineAdr = '0, iFlipAdr = '0;
  logic             iLineWrEn = 1'b0, iFlipWrEn = 1'b0;
  logic [ADR_W-1:0] oAdr;
  logic [COL_W-1:0] oD;

  draw_sched #(.ADR_W(ADR_W), .CRD_W(CRD_W), .COL_W(COL_W)) dut (
    .iClk(iClk), .iRst_(iRst_), .iGo(iGo), .iPolyline(iPolyline),
    .iTriangle(iTriangle), .iFlip(iFlip), .iColor(iColor),
    .iX0(iX0), .iY0(iY0), .iX1(iX1), .iY1(iY1), .iX2(iX2), .iY2(iY2),
    .oDone(oDone), .oLineGo(oLineGo), .oLineX0(oLineX0), .oLineY0(oLineY0),
    .oLineX1(oLineX1), .oLineY1(oLineY1), .iLineDone(iLineDone),
    .iLineAdr(iLineAdr), .iLineWrEn(iLineWrEn), .oFlipGo(oFlipGo),
    .iFlipDone(iFlipDone), .iFlipAdr(iFlipAdr), .iFlipWrEn(iFlipWrEn),
    .oAdr(oAdr), .oD(oD), .oWrEn(oWrEn), .oBusyErr(oBusyErr), .oCmdErr(oCmdErr)
  );

  always #5 iClk = ~iClk;

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- engine models ----------------
  int g_llat = 5;
  int g_flat = 4;
  int lcnt = 0;
  int fcnt = 0;

  always @(posedge iClk or negedge iRst_) begin
    if (!iRst_) begin
      iLineDone <= 1'b1; lcnt <= 0;
      iFlipDone <= 1'b1; fcnt <= 0;
    end else begin
      if (oLineGo) begin
        iLineDone <= 1'b0; lcnt <= g_llat - 1;
      end else if (lcnt > 0) begin
        lcnt <= lcnt - 1;
        if (lcnt == 1) iLineDone <= 1'b1;
      end
      if (oFlipGo) begin
        iFlipDone <= 1'b0; fcnt <= g_flat - 1;
      end else if (fcnt > 0) begin
        fcnt <= fcnt - 1;
        if (fcnt == 1) iFlipDone <= 1'b1;
      end
    end
  end

  // Write requests toggle randomly at all times, including while idle.
  always @(posedge iClk) begin
    iLineAdr  <= ADR_W'($urandom);
    iLineWrEn <= 1'($urandom);
    iFlipAdr  <= ADR_W'($urandom);
    iFlipWrEn <= 1'($urandom);
  end

  // ---------------- behavioural model ----------------
  // A command is a list of segments (or one flip). Each segment gets a go
  // cycle, a guard cycle, then waits for the engine done.
  logic             m_busy = 1'b0;
  logic             m_flip = 1'b0;
  int               m_age = 0;
  int               m_idx = 0;
  int               m_nseg = 0;
  logic [31:0]      m_seg [3];
  logic [COL_W-1:0] m_col = '0;
  logic [ADR_W-1:0] m_lastadr = '0;
  logic             m_berr = 1'b0, m_cerr = 1'b0;

  always @(posedge iClk or negedge iRst_) begin
    if (!iRst_) begin
      m_busy = 1'b0; m_flip = 1'b0; m_age = 0; m_idx = 0; m_nseg = 0;
      m_col = '0; m_lastadr = '0; m_berr = 1'b0; m_cerr = 1'b0;
    end else if (m_busy) begin
      if (iGo) m_berr = 1'b1;
      m_lastadr = m_flip ? iFlipAdr : iLineAdr;
      if (m_age >= 2 && (m_flip ? iFlipDone : iLineDone)) begin
        if (m_idx + 1 < m_nseg) begin
          m_idx++; m_age = 0;
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        m_age++;
      end
    end else if (iGo) begin
      if (int'(iPolyline) + int'(iTriangle) + int'(iFlip) == 1) begin
        m_busy = 1'b1; m_flip = iFlip; m_age = 0; m_idx = 0;
        m_col = iColor;
        m_seg[0] = {iX0, iY0, iX1, iY1};
        m_seg[1] = {iX1, iY1, iX2, iY2};
        m_seg[2] = {iX2, iY2, iX0, iY0};
        m_nseg = iTriangle ? 3 : 1;
      end else begin
        m_cerr = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge iClk) begin
    chk("done", 32'(oDone), 32'(!m_busy));
    chk("linego", 32'(oLineGo), 32'(m_busy && !m_flip && m_age == 0));
    chk("flipgo", 32'(oFlipGo), 32'(m_busy && m_flip && m_age == 0));
    chk("wren", 32'(oWrEn), 32'(m_busy ? (m_flip ? iFlipWrEn : iLineWrEn) : 1'b0));
    chk("adr", 32'(oAdr), 32'(m_busy ? (m_flip ? iFlipAdr : iLineAdr) : m_lastadr));
    chk("data", 32'(oD), 32'(m_col));
    chk("busyerr", 32'(oBusyErr), 32'(m_berr));
    chk("cmderr", 32'(oCmdErr), 32'(m_cerr));
    if (m_busy && !m_flip)
      chk("endpoints", {oLineX0, oLineY0, oLineX1, oLineY1}, m_seg[m_idx]);
  end

  // Go-pulse log for the literal checks.
  logic [31:0] q_seg[$];
  int          n_flipgo = 0;
  always @(negedge iClk) begin
    if (iRst_) begin
      if (oLineGo) q_seg.push_back({oLineX0, oLineY0, oLineX1, oLineY1});
      if (oFlipGo) n_flipgo++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge iClk); #2;
  endtask

  task automatic do_go(input logic pl, input logic tr, input logic fl,
                       input logic [COL_W-1:0] col,
                       input logic [CRD_W-1:0] x0, input logic [CRD_W-1:0] y0,
                       input logic [CRD_W-1:0] x1, input logic [CRD_W-1:0] y1,
                       input logic [CRD_W-1:0] x2, input logic [CRD_W-1:0] y2);
    iGo = 1'b1; iPolyline = pl; iTriangle = tr; iFlip = fl; iColor = col;
    iX0 = x0; iY0 = y0; iX1 = x1; iY1 = y1; iX2 = x2; iY2 = y2;
    tick();
    iGo = 1'b0; iPolyline = 1'b0; iTriangle = 1'b0; iFlip = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      if (oDone) break;
      tick();
    end
    chk("idle_timeout", 32'(oDone), 32'd1);
  endtask

  task automatic clear_log();
    q_seg.delete();
    n_flipgo = 0;
  endtask

  task automatic pulse_reset();
    iRst_ = 1'b0;
    tick();
    tick();
    iRst_ = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst_ = 1'b0;
    tick(); tick();
    iRst_ = 1'b1;
    tick();

    // reset state
    chk("rst_done", 32'(oDone), 32'd1);
    chk("rst_wren", 32'(oWrEn), 32'd0);
    chk("rst_adr", 32'(oAdr), 32'd0);
    chk("rst_errs", {oBusyErr, oCmdErr}, 32'd0);

    // polyline (10,20)->(30,40), color 1FF, engine done 5 cycles after go
    clear_log();
    g_llat = 5;
    do_go(1, 0, 0, 9'h1FF, 8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd0);
    chk("poly_go_now", 32'(oLineGo), 32'd1);
    tick();
    for (int i = 0; i < 30; i++) begin
      if (iLineDone) break;
      tick();
    end
    chk("poly_done_wait", 32'(iLineDone), 32'd1);
    chk("poly_busy_at_done", 32'(oDone), 32'd0);
    tick();
    chk("poly_done_rise", 32'(oDone), 32'd1);
    chk("poly_d", 32'(oD), 32'h1FF);
    chk("poly_ngo", q_seg.size(), 32'd1);
    if (q_seg.size() >= 1) chk("poly_seg", q_seg[0], 32'h0A141E28);

    // triangle (0,0),(100,0),(50,80)
    clear_log();
    g_llat = 3;
    do_go(0, 1, 0, 9'h0A5, 8'd0, 8'd0, 8'd100, 8'd0, 8'd50, 8'd80);
    wait_idle(100);
    chk("tri_ngo", q_seg.size(), 32'd3);
    if (q_seg.size() >= 3) begin
      chk("tri_seg0", q_seg[0], 32'h00006400);
      chk("tri_seg1", q_seg[1], 32'h64003250);
      chk("tri_seg2", q_seg[2], 32'h32500000);
    end

    // flip
    clear_log();
    g_flat = 4;
    do_go(0, 0, 1, 9'h013, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
    chk("flip_go_now", 32'(oFlipGo), 32'd1);
    wait_idle(50);
    chk("flip_nflip", 32'(n_flipgo), 32'd1);
    chk("flip_nline", q_seg.size(), 32'd0);

    // invalid flag combinations
    clear_log();
    do_go(1, 0, 1, 9'h001, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3);
    chk("cmd_multi_err", 32'(oCmdErr), 32'd1);
    chk("cmd_multi_idle", 32'(oDone), 32'd1);
    tick();
    chk("cmd_multi_nogo", q_seg.size() + n_flipgo, 32'd0);
    pulse_reset();
    chk("cmd_err_cleared", 32'(oCmdErr), 32'd0);
    do_go(0, 0, 0, 9'h001, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3);
    chk("cmd_none_err", 32'(oCmdErr), 32'd1);
    tick();
    chk("cmd_none_nogo", q_seg.size() + n_flipgo, 32'd0);

    // iGo during FWAIT, then iGo in the cycle oDone rises
    clear_log();
    g_flat = 6;
    do_go(0, 0, 1, 9'h0F0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    tick(); tick(); tick();
    chk("busy_pre", 32'(oBusyErr), 32'd0);
    do_go(1, 0, 0, 9'h111, 8'd7, 8'd7, 8'd9, 8'd9, 8'd0, 8'd0);
    chk("busy_err", 32'(oBusyErr), 32'd1);
    wait_idle(50);
    chk("busy_flip_ok", 32'(n_flipgo), 32'd1);
    chk("busy_no_line", q_seg.size(), 32'd0);
    g_llat = 2;
    do_go(1, 0, 0, 9'h0C3, 8'd5, 8'd6, 8'd5, 8'd6, 8'd0, 8'd0);
    chk("edge_accept", 32'(oLineGo), 32'd1);
    chk("degen_seg", {oLineX0, oLineY0, oLineX1, oLineY1}, 32'h05060506);
    wait_idle(50);

    // reset asserted mid-LWAIT
    g_llat = 20;
    do_go(1, 0, 0, 9'h1AA, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0);
    tick(); tick(); tick();
    chk("mid_busy", 32'(oDone), 32'd0);
    iRst_ = 1'b0;
    #1;
    chk("mid_rst_done", 32'(oDone), 32'd1);
    chk("mid_rst_wren", 32'(oWrEn), 32'd0);
    chk("mid_rst_errs", {oBusyErr, oCmdErr}, 32'd0);
    chk("mid_rst_linego", 32'(oLineGo), 32'd0);
    tick();
    iRst_ = 1'b1;
    clear_log();
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_nogo", q_seg.size(), 32'd0);
    chk("post_rst_done", 32'(oDone), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
